herm_ifft_streamer: RTL
=======================

# herm_ifft_streamer

Downstream companion of the Hermitian buffer in the SoC VLC OFDM transmitter.
- Waits for the buffer's full flag, then walks its read pointer over all FFT_POINT*SYMBOL_NUM Hermitian-symmetric words.
- Unpacks each 16-bit word into a sign-extended 32-bit complex sample.
- Streams the samples to the IFFT core over AXI4-Stream with per-symbol tlast and full tready backpressure.
- Pulses `tx_done` at frame end to clear the buffer for the next burst.

## Interface
Parameters:
- FFT_POINT, 64, samples per OFDM symbol (power of two)
- SYMBOL_NUM, 8, symbols per burst
- PTR_W, 10, read pointer width; must satisfy 2^PTR_W >= FFT_POINT*SYMBOL_NUM

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  permits a new frame to start; sampled only in IDLE
- buff_full  in  1  Hermitian buffer output-full flag
- read_ptr  out  PTR_W  buffer read address; buffer returns data one cycle later
- buff_dout  in  16  buffer read data: [15:8] imag, [7:0] real, both signed 8-bit
- tx_done  out  1  one-cycle pulse clearing the buffer
- m_axis_tdata  out  32  {sext16(imag), sext16(real)}
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready from IFFT
- m_axis_tlast  out  1  high on the last sample of each symbol
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE -> STREAM when enable && buff_full.
  - STREAM -> DONE after the handshake of beat FFT_POINT*SYMBOL_NUM-1.
  - DONE (1 cycle, tx_done=1) -> WAIT_CLR.
  - WAIT_CLR -> IDLE when buff_full==0.
- Issue counter `read_ptr` starts at 0 and advances by one per buffer read. A read is issued only when the 2-entry output queue will have room for the returning word, counting reads already in flight. After issuing address FFT_POINT*SYMBOL_NUM-1, read_ptr holds that value; no further reads.
- Return path: the word read in cycle N is captured into the queue at N+1. The queue head drives tdata/tvalid. A pop occurs on tvalid && tready.
- Beat counter (0..FFT_POINT*SYMBOL_NUM-1) increments per handshake. tlast = (beat[log2(FFT_POINT)-1:0] == FFT_POINT-1).
- Data formatting: imag = buff_dout[15:8], real = buff_dout[7:0], each sign-extended to 16 bits. No scaling or saturation.
- tvalid never drops without a handshake. tdata and tlast are stable while tvalid && !tready (AXIS rules).
- buff_full falling during STREAM is ignored; the frame completes.
- enable low during STREAM does not abort the frame.
- rst at any time returns all state to IDLE and empties the queue. An aborted frame is not resumed.

## Timing
- Reset values: read_ptr=0, tx_done=0, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0.
- Latency: buff_full && enable sampled high at cycle T gives first read_ptr=0 issue at T+1 and first tvalid at T+3.
- With tready held high: one beat per cycle, frame of 512 beats contiguous (default parameters).
- tx_done is high exactly one cycle, one cycle after the final handshake.
- tready low for k cycles stalls output k cycles with no lost or duplicated samples. At most 2 words are buffered.
- buff_full already high when entering WAIT_CLR: the FSM waits there until the buffer clears it.

## Configuration
- HERM_STREAM_TUSER_EN defined:
  - Adds output m_axis_tuser[7:0] = symbol index (beat >> log2(FFT_POINT)).
  - Reset value 0; stable under stall like tdata.
- HERM_STREAM_TUSER_EN undefined: port absent; no symbol-index logic.

## Test plan
- Reset mid-STREAM after 100 beats:
  - Required: all outputs at reset values the same cycle.
  - Required: a new frame restarts at read_ptr=0, beat 0.
- Frame with tready=1, buff_dout = read_ptr-derived pattern ({~addr[7:0], addr[7:0]}):
  - Required: 512 beats in order with correct sign extension (addr 0x80 real -> 0xFF80).
  - Required: tlast on beats 63,127,...,511; tx_done at beat511+1.
- Random tready (50% duty):
  - Required: identical 512-beat sequence, no drops/duplicates.
  - Required: tdata/tlast stable during stalls; read_ptr never more than 2 ahead of the beat count.
- Word 0x80_7F:
  - Required: tdata=0xFF80_007F.
  - Required: word 0x00_00 -> tdata=0x0000_0000.
- buff_full held high after tx_done for 5 cycles:
  - Required: FSM stays in WAIT_CLR with busy=1 and no second frame.
  - Required: busy drops one cycle after buff_full low.
- enable=0 with buff_full=1:
  - Required: no reads or tvalid.
  - Required: raising enable starts the frame per the Timing latency (first tvalid at T+3).

Source files
------------

// File: rtl/herm_ifft_streamer_if.sv
// AXI4-Stream link from the Hermitian IFFT streamer to the IFFT core.
// Optional symbol-index sideband is present when HERM_STREAM_TUSER_EN is defined.
interface herm_ifft_streamer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
`ifdef HERM_STREAM_TUSER_EN
  logic [7:0]  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/herm_ifft_streamer.sv
// Drains a full Hermitian buffer and streams sign-extended complex samples to the IFFT over AXIS.
// Define HERM_STREAM_TUSER_EN to drive m_axis.tuser with the symbol index of the current beat.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable && buff_full
// STREAM   | issuing buffer reads and emitting beats until the last handshake
// DONE     | one-cycle tx_done pulse to clear the buffer
// WAIT_CLR | holding until the buffer drops its full flag
module herm_ifft_streamer #(
  parameter int FFT_POINT  = 64,
  parameter int SYMBOL_NUM = 8,
  parameter int PTR_W      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 buff_full,
  output logic [PTR_W-1:0]     read_ptr,
  input  logic [15:0]          buff_dout,
  output logic                 tx_done,
  output logic                 busy,
  herm_ifft_streamer_if.master m_axis
);

  localparam int LOG2_FFT = $clog2(FFT_POINT);
  localparam int TOTAL    = FFT_POINT * SYMBOL_NUM;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TOTAL - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STREAM   = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_WAIT_CLR = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] read_ptr_q, read_ptr_d;
  logic             rd_done_q, rd_done_d;
  logic             rd_pend_q, rd_pend_d;
  logic [1:0]       q_cnt_q, q_cnt_d;
  logic [31:0]      q0_q, q0_d;
  logic [31:0]      q1_q, q1_d;
  logic [PTR_W-1:0] beat_q, beat_d;

  logic        tvalid;
  logic        pop;
  logic        push;
  logic        issue;
  logic        last_hs;
  logic [1:0]  occ_next;
  logic [31:0] new_word;

  function automatic logic [31:0] fmt_word(input logic [15:0] w);
    return {{8{w[15]}}, w[15:8], {8{w[7]}}, w[7:0]};
  endfunction

  assign tvalid   = (q_cnt_q != 2'd0);
  assign pop      = tvalid && m_axis.tready;
  assign push     = rd_pend_q;
  assign new_word = fmt_word(buff_dout);
  assign last_hs  = pop && (beat_q == LAST_PTR);

  // Queue occupancy after this cycle's pop, counting the word still in flight from the RAM.
  assign occ_next = q_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  assign issue    = (state_q == ST_STREAM) && !rd_done_q && (occ_next <= 2'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (enable && buff_full) state_d = ST_STREAM;
      ST_STREAM:   if (last_hs)             state_d = ST_DONE;
      ST_DONE:                              state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!buff_full)          state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read_ptr_d = read_ptr_q;
    rd_done_d  = rd_done_q;
    rd_pend_d  = issue;
    if (state_q != ST_STREAM) begin
      read_ptr_d = '0;
      rd_done_d  = 1'b0;
    end else if (issue) begin
      if (read_ptr_q == LAST_PTR) rd_done_d  = 1'b1;
      else                        read_ptr_d = read_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (state_q != ST_STREAM) beat_d = '0;
    else if (pop)             beat_d = last_hs ? '0 : beat_q + PTR_W'(1);
  end

  // Two-entry queue: q0 is the head and drives tdata, so it only moves on a pop.
  always_comb begin
    q0_d    = q0_q;
    q1_d    = q1_q;
    q_cnt_d = q_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (q_cnt_q == 2'd0) q0_d = new_word;
        else                 q1_d = new_word;
        q_cnt_d = q_cnt_q + 2'd1;
      end
      2'b01: begin
        q0_d    = q1_q;
        q_cnt_d = q_cnt_q - 2'd1;
      end
      2'b11: begin
        if (q_cnt_q == 2'd1) begin
          q0_d = new_word;
        end else begin
          q0_d = q1_q;
          q1_d = new_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      read_ptr_q <= '0;
      rd_done_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      q_cnt_q    <= 2'd0;
      q0_q       <= '0;
      q1_q       <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      read_ptr_q <= read_ptr_d;
      rd_done_q  <= rd_done_d;
      rd_pend_q  <= rd_pend_d;
      q_cnt_q    <= q_cnt_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      beat_q     <= beat_d;
    end
  end

  assign read_ptr      = read_ptr_q;
  assign tx_done       = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign m_axis.tdata  = q0_q;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tvalid && (beat_q[LOG2_FFT-1:0] == {LOG2_FFT{1'b1}});
`ifdef HERM_STREAM_TUSER_EN
  assign m_axis.tuser  = 8'(beat_q >> LOG2_FFT);
`endif

endmodule
